// File: rtl/pinbus_pkg.sv
// Shared encodings and pin-window defaults for the pin-controller configuration bus.
// The defaults are also used by the top-level pincontrol generate block.
package pinbus_pkg;

  localparam int DEF_NUM_PINS   = 16;
  localparam int DEF_PIN_STRIDE = 32;
  localparam int DEF_PIN_BASE   = 0;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_H    = 2'd1,
    OWN_C    = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_H = 2'd1,
    S_OWN_C = 2'd2
  } state_e;

endpackage

// File: rtl/pinbus_rr_pick.sv
// Two-way round-robin decision: a lone requester wins, a tie goes to whoever did not own last.
module pinbus_rr_pick
  import pinbus_pkg::*;
(
  input  logic       i_h_want,
  input  logic       i_c_want,
  input  logic [1:0] i_last,
  output logic [1:0] o_pick
);

  always_comb begin
    o_pick = OWN_NONE;
    if (i_h_want && i_c_want) begin
      o_pick = (i_last == OWN_H) ? OWN_C : OWN_H;
    end else if (i_h_want) begin
      o_pick = OWN_H;
    end else if (i_c_want) begin
      o_pick = OWN_C;
    end
  end

endmodule

// File: rtl/pin_bus_arbiter.sv
// Arbitrates the pin-controller config bus between the EBI host and the command sequencer.
// Define PINBUS_ADDR_CHECK_EN to add the o_err output and block accesses outside the pin windows.
module pin_bus_arbiter
  import pinbus_pkg::*;
#(
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 16,
  parameter int NUM_PINS   = DEF_NUM_PINS,
  parameter int PIN_STRIDE = DEF_PIN_STRIDE,
  parameter int PIN_BASE   = DEF_PIN_BASE,
  parameter int TIMEOUT    = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_h_req,
  input  logic              i_h_lock,
  input  logic              i_h_wr,
  input  logic [ADDR_W-1:0] i_h_addr,
  input  logic [DATA_W-1:0] i_h_wdata,
  input  logic              i_c_req,
  input  logic              i_c_lock,
  input  logic              i_c_wr,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [DATA_W-1:0] i_c_wdata,
  output logic              o_h_gnt,
  output logic              o_h_ack,
  output logic [DATA_W-1:0] o_h_rdata,
  output logic              o_c_gnt,
  output logic              o_c_ack,
  output logic [DATA_W-1:0] o_c_rdata,
  output logic              o_bus_en,
  output logic              o_bus_wr,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic [DATA_W-1:0] i_bus_rdata,
  output logic              o_lock_timeout
`ifdef PINBUS_ADDR_CHECK_EN
  ,
  output logic              o_err
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  // A pin window that cannot be addressed is a configuration error, caught at elaboration.
  if ((TIMEOUT < 2) || (PIN_BASE + NUM_PINS * PIN_STRIDE > (1 << ADDR_W))) begin : g_bad_cfg
    $error("pin_bus_arbiter: TIMEOUT < 2 or pin window exceeds address space");
  end

  state_e            r_state, w_state_nxt;
  logic [1:0]        r_last, w_last_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_lock_to, w_force;
  logic              w_h_want, w_c_want;
  logic [1:0]        w_pick;

  assign w_h_want = i_h_req | i_h_lock;
  assign w_c_want = i_c_req | i_c_lock;

  pinbus_rr_pick u_rr_pick (
    .i_h_want (w_h_want),
    .i_c_want (w_c_want),
    .i_last   (r_last),
    .o_pick   (w_pick)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_last    <= OWN_C;
      r_cnt     <= '0;
      r_lock_to <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_lock_to <= w_force;
    end
  end

  // An owner keeps the bus while requesting; an idle lock is held until the watchdog expires.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cnt_nxt   = '0;
    w_force     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick == OWN_H) begin
          w_state_nxt = S_OWN_H;
        end else if (w_pick == OWN_C) begin
          w_state_nxt = S_OWN_C;
        end
      end
      S_OWN_H: begin
        if (!i_h_req) begin
          if (!i_h_lock || (r_cnt == CNT_MAX)) begin
            w_force    = i_h_lock;
            w_last_nxt = OWN_H;
            if (w_c_want) w_state_nxt = S_OWN_C;
            else          w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_OWN_C: begin
        if (!i_c_req) begin
          if (!i_c_lock || (r_cnt == CNT_MAX)) begin
            w_force    = i_c_lock;
            w_last_nxt = OWN_C;
            if (w_h_want) w_state_nxt = S_OWN_H;
            else          w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  logic              w_h_acc, w_c_acc, w_acc, w_wr, w_addr_ok;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  assign w_h_acc = (r_state == S_OWN_H) && i_h_req;
  assign w_c_acc = (r_state == S_OWN_C) && i_c_req;
  assign w_acc   = w_h_acc | w_c_acc;
  assign w_wr    = w_h_acc ? i_h_wr    : i_c_wr;
  assign w_addr  = w_h_acc ? i_h_addr  : i_c_addr;
  assign w_wdata = w_h_acc ? i_h_wdata : i_c_wdata;

`ifdef PINBUS_ADDR_CHECK_EN
  localparam int WIN_WORDS = NUM_PINS * PIN_STRIDE;
  logic [ADDR_W:0] w_off;
  assign w_off     = {1'b0, w_addr} - (ADDR_W + 1)'(PIN_BASE);
  assign w_addr_ok = !w_off[ADDR_W] && (w_off[ADDR_W-1:0] < ADDR_W'(WIN_WORDS));
`else
  assign w_addr_ok = 1'b1;
`endif

  logic              r_bus_en, r_bus_wr, r_s1_vld, r_s1_wr, r_s1_err;
  logic [1:0]        r_s1_tag;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic              r_h_ack, r_c_ack, r_ack_rd;

  // Each transfer carries its owner tag down the pipe so acks survive a grant handover.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bus_en    <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_s1_vld    <= 1'b0;
      r_s1_tag    <= OWN_NONE;
      r_s1_wr     <= 1'b0;
      r_s1_err    <= 1'b0;
      r_h_ack     <= 1'b0;
      r_c_ack     <= 1'b0;
      r_ack_rd    <= 1'b0;
    end else begin
      r_bus_en <= w_acc && w_addr_ok;
      r_bus_wr <= w_acc && w_addr_ok && w_wr;
      if (w_acc && w_addr_ok) begin
        r_bus_addr  <= w_addr;
        r_bus_wdata <= w_wdata;
      end
      r_s1_vld <= w_acc;
      r_s1_tag <= w_h_acc ? OWN_H : OWN_C;
      r_s1_wr  <= w_wr;
      r_s1_err <= !w_addr_ok;
      r_h_ack  <= r_s1_vld && (r_s1_tag == OWN_H);
      r_c_ack  <= r_s1_vld && (r_s1_tag == OWN_C);
      r_ack_rd <= r_s1_vld && !r_s1_wr && !r_s1_err;
    end
  end

`ifdef PINBUS_ADDR_CHECK_EN
  logic r_err;
  always_ff @(posedge i_clk) begin
    if (i_reset) r_err <= 1'b0;
    else         r_err <= r_s1_vld && r_s1_err;
  end
  assign o_err = r_err;
`endif

  assign o_h_gnt        = (r_state == S_OWN_H);
  assign o_c_gnt        = (r_state == S_OWN_C);
  assign o_h_ack        = r_h_ack;
  assign o_c_ack        = r_c_ack;
  assign o_h_rdata      = (r_h_ack && r_ack_rd) ? i_bus_rdata : '0;
  assign o_c_rdata      = (r_c_ack && r_ack_rd) ? i_bus_rdata : '0;
  assign o_bus_en       = r_bus_en;
  assign o_bus_wr       = r_bus_wr;
  assign o_bus_addr     = r_bus_addr;
  assign o_bus_wdata    = r_bus_wdata;
  assign o_lock_timeout = r_lock_to;

endmodule

// File: doc/pin_bus_arbiter.md
Name: pin_bus_arbiter

Overview:
- Shares the single pin-controller configuration bus (address/write-data/read-data fan-out to all pincontrol instances) between two requesters: the EBI host path and the internal command sequencer.
- Round-robin arbitration with an optional lock for atomic multi-word pin configuration (6 words per pin), plus a lock watchdog.
- Sits between ebi_interface/command sequencer and the pincontrol generate block in the mecobo top level.

Parameters:
- ADDR_W, 21, bus address width
- DATA_W, 16, bus data width
- NUM_PINS, 16, pin controllers on the bus
- PIN_STRIDE, 32, words per pin window (POSITION = i*PIN_STRIDE)
- PIN_BASE, 0, address of pin 0 window
- TIMEOUT, 64, idle-lock cycles before forced release (>=2)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- h_req / c_req  in  1  host / cmd transfer request
- h_lock / c_lock  in  1  hold grant across gaps between transfers
- h_wr / c_wr  in  1  1=write, 0=read
- h_addr / c_addr  in  ADDR_W  word address
- h_wdata / c_wdata  in  DATA_W  write data
- h_gnt / c_gnt  out  1  bus granted to requester
- h_ack / c_ack  out  1  one-cycle completion pulse
- h_rdata / c_rdata  out  DATA_W  read data, valid with ack
- bus_en  out  1  transfer strobe to pin controllers
- bus_wr  out  1  write strobe
- bus_addr  out  ADDR_W  address to pin controllers
- bus_wdata  out  DATA_W  write data to pin controllers
- bus_rdata  in  DATA_W  read data returned by pin controllers (1-cycle latency after bus_en)
- lock_timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset: state IDLE, all outputs 0, last_owner=CMD (host wins first tie), idle counter 0.
- States: IDLE, OWN_H, OWN_C. gnt_x = (state==OWN_x), registered.
- IDLE: h_req|h_lock only -> OWN_H; c_req|c_lock only -> OWN_C; both -> owner != last_owner. Grant visible cycle after request seen.
- Accept: posedge where gnt_x & req_x. One transfer per cycle; back-to-back allowed.
- Latency: accept at T -> bus_en/bus_wr/bus_addr/bus_wdata valid T+1 (bus_en, bus_wr high exactly one cycle per transfer; addr/wdata hold last value otherwise) -> x_ack and x_rdata valid T+2 (rdata = bus_rdata sampled; for writes rdata = 0). Pipeline up to 2 in flight; acks routed by a per-stage owner tag, so acks complete correctly even after ownership changes.
- Release from OWN_x when req_x=0 and lock_x=0: set last_owner=x; other requesting -> OWN_other directly next cycle; else IDLE. No dead cycle beyond the registered grant.
- Watchdog: in OWN_x, counter increments each cycle req_x=0, clears on req_x=1 or state change. Counter == TIMEOUT-1 with lock_x still high -> forced release as above, lock_timeout pulses; requester must drop lock and re-request (lock still high in IDLE counts as request, re-granted only via round robin).
- Ownership never changes while req_x=1 of the current owner (no preemption).
- Reset mid-transfer: in-flight transfers dropped, no ack issued.

Optional Feature:
- PINBUS_ADDR_CHECK_EN: adds output err (1-bit, same-cycle as ack). Accepted address outside [PIN_BASE, PIN_BASE+NUM_PINS*PIN_STRIDE-1] -> no bus_en; ack at T+2 with err=1, rdata=0. Without macro: no err port, all addresses forwarded unchanged.

Decomposition:
- Shared package pinbus_pkg: owner encoding (OWN_NONE/OWN_H/OWN_C), state encoding, default PIN_STRIDE/NUM_PINS/PIN_BASE constants (also used by top-level generate).
- One sub-module: pinbus_rr_pick (2-way round-robin decision from requests and last_owner). The response pipeline stays inline.

Test Plan:
- Host write addr 0x0021 data 0xBEEF alone -> h_gnt next cycle, bus_en/bus_wr high one cycle with addr 0x0021 data 0xBEEF, h_ack 2 cycles after accept, c_ack never.
- Both request at once after reset -> host granted first; host drops req -> c_gnt next cycle; both again -> cmd then host (alternation).
- Cmd holds lock, 6 writes at 0x40..0x45 with 3-cycle gaps while host requests -> all 6 on bus contiguous to cmd, host granted only after c_lock drops.
- Cmd lock held, req low 64 cycles -> lock_timeout pulse at cycle 64, grant moves to waiting host.
- Host read 0x0005, bus_rdata=0x1234 cycle after bus_en -> h_rdata=0x1234 with h_ack; reset asserted cycle after accept -> no ack, all outputs 0.
- With PINBUS_ADDR_CHECK_EN, host read 0x0200 (NUM_PINS=16) -> no bus_en, h_ack with err=1, rdata=0.
